// File: rtl/eng_wrapper_pkg.sv
// eng_wrapper_pkg: shared types and defaults for the engine sequencing controller.
//   state_t           - controller state encoding
//   DEF_NUM_RUNS      - default number of engine runs per request
//   DEF_BUSY_TIMEOUT  - default busy watchdog length in cycles (ENG_TIMEOUT_EN builds)
package eng_wrapper_pkg;

    localparam int DEF_NUM_RUNS     = 4;
    localparam int DEF_BUSY_TIMEOUT = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REL,
        INIT,
        LAUNCH,
        WAIT_BUSY,
        WAIT_READY,
        NEXT,
        FINISH
    } state_t;

endpackage

// File: rtl/eng_wrapper_if.sv
// eng_wrapper_if: user/engine handshake bundle of the sequencing controller.
//   start     - user request level (master -> slave)
//   eng_done  - engine ready, low while busy (master -> slave)
//   done      - all runs complete (slave -> master)
//   eng_start - one-cycle engine launch pulse (slave -> master)
//   inc_count - one-cycle pulse after each completed run (slave -> master)
//   rst_count - one-cycle pulse clearing run counters (slave -> master)
// The controller uses the slave modport; the user/engine side uses master.
interface eng_wrapper_if;

    logic start;
    logic eng_done;
    logic done;
    logic eng_start;
    logic inc_count;
    logic rst_count;

    modport master (
        output start, eng_done,
        input  done, eng_start, inc_count, rst_count
    );

    modport slave (
        input  start, eng_done,
        output done, eng_start, inc_count, rst_count
    );

endinterface

// File: rtl/eng_wrapper_run_counter.sv
// run_counter: synchronous clear/increment counter with terminal-count flag.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - synchronous clear (wins over inc)
//   inc      - increment by one
//   tc       - high while the count equals TERM
module run_counter #(
    parameter int W    = 3,
    parameter int TERM = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + W'(1);
    end

    assign tc = (count == W'(TERM));

endmodule

// File: rtl/eng_wrapper.sv
// eng_wrapper: runs an external engine NUM_RUNS times per user request.
//   clk, rst - system clock, asynchronous active-high reset
//   bus      - eng_wrapper_if.slave: start/eng_done in; done/eng_start/
//              inc_count/rst_count out (all Moore-decoded from state)
// Optional build macro ENG_TIMEOUT_EN adds a BUSY_TIMEOUT-cycle watchdog on
// WAIT_BUSY; a run whose engine never drops eng_done is then treated as done.
//
// state      | meaning
// IDLE       | waiting for start
// WAIT_REL   | start seen, waiting for its release
// INIT       | rst_count pulse, run count cleared
// LAUNCH     | eng_start pulse
// WAIT_BUSY  | waiting for engine to go busy (eng_done low)
// WAIT_READY | waiting for engine to finish (eng_done high)
// NEXT       | inc_count pulse, run count advanced
// FINISH     | done held until the next start
module eng_wrapper
    import eng_wrapper_pkg::*;
#(
    parameter int NUM_RUNS = DEF_NUM_RUNS,
    parameter int CNT_W    = $clog2(NUM_RUNS + 1)
`ifdef ENG_TIMEOUT_EN
    , parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
`endif
) (
    input  logic          clk,
    input  logic          rst,
    eng_wrapper_if.slave  bus
);

    state_t state;
    state_t state_nxt;
    logic   last_run;
    logic   busy_expired;

    // Terminal compare sits on the pre-increment value in NEXT, so the
    // counter tops out at NUM_RUNS and never wraps.
    run_counter #(
        .W    (CNT_W),
        .TERM (NUM_RUNS - 1)
    ) u_runs (
        .clk (clk),
        .rst (rst),
        .clr (state == INIT),
        .inc (state == NEXT),
        .tc  (last_run)
    );

`ifdef ENG_TIMEOUT_EN
    // Held clear outside WAIT_BUSY, so it reads 0 on the first busy-wait
    // cycle and flags on the BUSY_TIMEOUT-th.
    run_counter #(
        .W    ($clog2(BUSY_TIMEOUT + 1)),
        .TERM (BUSY_TIMEOUT - 1)
    ) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (state != WAIT_BUSY),
        .inc (state == WAIT_BUSY),
        .tc  (busy_expired)
    );
`else
    assign busy_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.start)                     state_nxt = WAIT_REL;
            WAIT_REL:   if (!bus.start)                    state_nxt = INIT;
            INIT:                                          state_nxt = LAUNCH;
            LAUNCH:                                        state_nxt = WAIT_BUSY;
            WAIT_BUSY:  if (!bus.eng_done || busy_expired) state_nxt = WAIT_READY;
            WAIT_READY: if (bus.eng_done)                  state_nxt = NEXT;
            NEXT:       state_nxt = last_run ? FINISH : LAUNCH;
            FINISH:     if (bus.start)                     state_nxt = WAIT_REL;
            default:                                       state_nxt = IDLE;
        endcase
    end

    assign bus.rst_count = (state == INIT);
    assign bus.eng_start = (state == LAUNCH);
    assign bus.inc_count = (state == NEXT);
    assign bus.done      = (state == FINISH);

endmodule

// File: tb/tb_eng_wrapper.sv
module tb_eng_wrapper;
    import eng_wrapper_pkg::*;

    logic clk;
    logic rst;
    logic model_en;

    int n_checks = 0;
    int n_fail   = 0;
    int n_es1 = 0, n_rc1 = 0, n_inc1 = 0;
    int n_es4 = 0, n_rc4 = 0, n_inc4 = 0;
    int s_es, s_rc, s_inc;
    logic found;
    int   n_seen;

    eng_wrapper_if bus1();
    eng_wrapper_if bus4();

    eng_wrapper #(.NUM_RUNS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    eng_wrapper #(.NUM_RUNS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // pulse monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (bus1.eng_start) n_es1++;
        if (bus1.rst_count) n_rc1++;
        if (bus1.inc_count) n_inc1++;
        if (bus4.eng_start) n_es4++;
        if (bus4.rst_count) n_rc4++;
        if (bus4.inc_count) n_inc4++;
    end

    // engine model for dut4: busy 1 cycle after eng_start, ready 5 cycles later
    initial begin
        bus4.eng_done = 1'b1;
        forever begin
            @(negedge clk);
            if (model_en && bus4.eng_start) begin
                @(negedge clk);
                bus4.eng_done = 1'b0;
                repeat (5) @(negedge clk);
                bus4.eng_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic at(input time t);
        if ($time < t) #(t - $time);
    endtask

    function automatic logic [3:0] outs1();
        return {bus1.done, bus1.eng_start, bus1.inc_count, bus1.rst_count};
    endfunction

    function automatic logic [3:0] outs4();
        return {bus4.done, bus4.eng_start, bus4.inc_count, bus4.rst_count};
    endfunction

    initial begin
        rst = 1'b1;
        model_en = 1'b1;
        bus1.start = 1'b0;
        bus1.eng_done = 1'b1;
        bus4.start = 1'b0;

        // reset
        at(120);
        chk("rst_outs1", 32'(outs1()), 32'h0);
        chk("rst_state1", 32'(dut1.state), 32'(IDLE));
        chk("rst_outs4", 32'(outs4()), 32'h0);
        chk("rst_state4", 32'(dut4.state), 32'(IDLE));
        at(200);
        rst = 1'b0;
        at(300);
        chk("post_rst_state1", 32'(dut1.state), 32'(IDLE));

        // single request, NUM_RUNS=1
        at(1000); bus1.start = 1'b1;
        at(1200);
        chk("s1_wait_rel", 32'(dut1.state), 32'(WAIT_REL));
        chk("s1_outs_idle", 32'(outs1()), 32'h0);
        at(1220); bus1.start = 1'b0;
        at(1270); bus1.eng_done = 1'b0;
        at(1300);
        chk("s1_rst_count", 32'(outs1()), 32'b0001);
        at(1400);
        chk("s1_eng_start", 32'(outs1()), 32'b0100);
        at(1500);
        chk("s1_busy_state", 32'(dut1.state), 32'(WAIT_BUSY));
        chk("s1_es_one_cycle", 32'(outs1()), 32'h0);
        at(1600);
        chk("s1_ready_state", 32'(dut1.state), 32'(WAIT_READY));
        at(8270); bus1.eng_done = 1'b1;
        at(8300);
        chk("s1_pre_inc", 32'(outs1()), 32'h0);
        at(8400);
        chk("s1_inc_count", 32'(outs1()), 32'b0010);
        at(8500);
        chk("s1_done", 32'(outs1()), 32'b1000);
        at(9020);
        chk("s1_done_held", 32'(bus1.done), 32'h1);
        chk("s1_n_eng_start", 32'(n_es1), 32'd1);
        chk("s1_n_rst_count", 32'(n_rc1), 32'd1);
        chk("s1_n_inc_count", 32'(n_inc1), 32'd1);

        // second request on dut1: eng_done stays high in WAIT_BUSY
        @(negedge clk); bus1.start = 1'b1;
        @(negedge clk);
        chk("s1_done_cleared", 32'(bus1.done), 32'h0);
        bus1.start = 1'b0;
        repeat (13) @(negedge clk);
        chk("s1_busy_hold", 32'(dut1.state), 32'(WAIT_BUSY));
        bus1.eng_done = 1'b0;
        @(negedge clk);
        chk("s1_busy_exit", 32'(dut1.state), 32'(WAIT_READY));
        bus1.eng_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("s1_done2", 32'(bus1.done), 32'h1);

        // multi-run with long start and an ignored mid-run start pulse
        s_es = n_es4; s_rc = n_rc4; s_inc = n_inc4;
        @(negedge clk); bus4.start = 1'b1;
        repeat (20) @(negedge clk);
        chk("m_long_start", 32'(dut4.state), 32'(WAIT_REL));
        chk("m_no_launch_yet", 32'(outs4()), 32'h0);
        bus4.start = 1'b0;
        @(negedge clk);
        chk("m_lat_rst_count", 32'(outs4()), 32'b0001);
        @(negedge clk);
        chk("m_lat_eng_start", 32'(outs4()), 32'b0100);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus4.inc_count) found = 1'b1;
        end
        chk("m_wait_inc1", 32'(found), 32'h1);
        @(negedge clk); bus4.start = 1'b1;
        @(negedge clk); bus4.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus4.done) found = 1'b1;
        end
        chk("m_wait_done", 32'(found), 32'h1);
        repeat (3) @(negedge clk);
        chk("m_done_held", 32'(dut4.state), 32'(FINISH));
        chk("m_n_eng_start", 32'(n_es4 - s_es), 32'd4);
        chk("m_n_inc_count", 32'(n_inc4 - s_inc), 32'd4);
        chk("m_n_rst_count", 32'(n_rc4 - s_rc), 32'd1);

        // reset in WAIT_READY of the third run
        @(negedge clk); bus4.start = 1'b1;
        @(negedge clk);
        chk("r_done_cleared", 32'(bus4.done), 32'h0);
        bus4.start = 1'b0;
        n_seen = 0;
        for (int i = 0; i < 100 && n_seen < 2; i++) begin
            @(negedge clk);
            if (bus4.inc_count) n_seen++;
        end
        chk("r_wait_inc2", 32'(n_seen), 32'd2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (dut4.state == WAIT_READY) found = 1'b1;
        end
        chk("r_wait_ready", 32'(found), 32'h1);
        #10;
        chk("r_count_before", 32'(dut4.u_runs.count), 32'd2);
        rst = 1'b1;
        #1;
        chk("r_outs4", 32'(outs4()), 32'h0);
        chk("r_state4", 32'(dut4.state), 32'(IDLE));
        chk("r_count_after", 32'(dut4.u_runs.count), 32'd0);
        chk("r_done1_cleared", 32'(bus1.done), 32'h0);
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("r_engine_idle", 32'(bus4.eng_done), 32'h1);
        s_es = n_es4; s_rc = n_rc4; s_inc = n_inc4;
        bus4.start = 1'b1;
        @(negedge clk); bus4.start = 1'b0;
        @(negedge clk);
        chk("r_fresh_rst_count", 32'(outs4()), 32'b0001);
        @(negedge clk);
        chk("r_count_restart", 32'(dut4.u_runs.count), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus4.done) found = 1'b1;
        end
        chk("r_wait_done", 32'(found), 32'h1);
        @(negedge clk);
        chk("r_n_eng_start", 32'(n_es4 - s_es), 32'd4);
        chk("r_n_inc_count", 32'(n_inc4 - s_inc), 32'd4);
        chk("r_n_rst_count", 32'(n_rc4 - s_rc), 32'd1);

`ifdef ENG_TIMEOUT_EN
        // watchdog: engine never goes busy, each run takes 19 cycles
        model_en = 1'b0;
        @(negedge clk); bus4.start = 1'b1;
        @(negedge clk); bus4.start = 1'b0;
        @(negedge clk);
        chk("t_rst_count", 32'(outs4()), 32'b0001);
        repeat (17) @(negedge clk);
        chk("t_busy_last", 32'(dut4.state), 32'(WAIT_BUSY));
        @(negedge clk);
        chk("t_timeout", 32'(dut4.state), 32'(WAIT_READY));
        repeat (58) @(negedge clk);
        chk("t_not_done_yet", 32'(bus4.done), 32'h0);
        @(negedge clk);
        chk("t_done", 32'(bus4.done), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
